// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: geometry, address fields
// and controller state encoding.
package dcache_pkg;

  localparam int unsigned NUM_LINES = 32;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IDX_W     = $clog2(NUM_LINES);
  localparam int unsigned OFF_W     = $clog2(LINE_BITS / 8);
  localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W    = $clog2(LINE_BITS / WORD_W);

  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned IDX_LSB   = OFF_W;
  localparam int unsigned TAG_LSB   = OFF_W + IDX_W;

  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [WSEL_W-1:0]    wsel_t;
  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StRefill
  } state_e;

  function automatic logic [ADDR_W-1:0] line_addr(tag_t tag, idx_t idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: valid/dirty/tag/data per line, asynchronous read,
// synchronous full-line refill and single-word store.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  idx_t  rd_idx_i,
  output logic  rd_valid_o,
  output logic  rd_dirty_o,
  output tag_t  rd_tag_o,
  output line_t rd_line_o,
  input  idx_t  wr_idx_i,
  input  logic  line_we_i,
  input  tag_t  line_tag_i,
  input  line_t line_data_i,
  input  logic  word_we_i,
  input  wsel_t word_sel_i,
  input  word_t word_data_i
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  tag_t                 r_tag  [NUM_LINES];
  line_t                r_line [NUM_LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (line_we_i) begin
      r_valid[wr_idx_i] <= 1'b1;
      r_dirty[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      r_dirty[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      r_tag[wr_idx_i]  <= line_tag_i;
      r_line[wr_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      r_line[wr_idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_data_i;
    end
  end

  assign rd_valid_o = r_valid[rd_idx_i];
  assign rd_dirty_o = r_dirty[rd_idx_i];
  assign rd_tag_o   = r_tag[rd_idx_i];
  assign rd_line_o  = r_line[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller: hit detection, word
// select/merge, and the miss FSM driving the line-wide memory port.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [WORD_W-1:0]    p1_data_i,
  output logic [WORD_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_e r_state;
  state_e w_state_next;
  tag_t   r_miss_tag;
  idx_t   r_miss_idx;

  logic   w_req;
  tag_t   w_tag;
  idx_t   w_idx;
  wsel_t  w_word;
  idx_t   w_rd_idx;
  idx_t   w_wr_idx;
  logic   w_rd_valid;
  logic   w_rd_dirty;
  tag_t   w_rd_tag;
  line_t  w_rd_line;
  logic   w_hit;
  logic   w_miss;
  logic   w_line_we;
  logic   w_word_we;
  logic   w_unused;

  assign w_req    = p1_MemRead_i | p1_MemWrite_i;
  assign w_tag    = p1_addr_i[TAG_LSB +: TAG_W];
  assign w_idx    = p1_addr_i[IDX_LSB +: IDX_W];
  assign w_word   = p1_addr_i[WORD_LSB +: WSEL_W];
  assign w_unused = ^p1_addr_i[WORD_LSB-1:0];

  // Miss states look up the latched index so the victim/refill line stays fixed.
  assign w_rd_idx  = (r_state == StIdle) ? w_idx : r_miss_idx;
  assign w_hit     = w_req && w_rd_valid && (w_rd_tag == w_tag);
  assign w_miss    = w_req && !w_hit;
  assign w_line_we = (r_state == StRefill) && mem_ack_i;
  assign w_word_we = (r_state == StIdle) && w_hit && p1_MemWrite_i;
  assign w_wr_idx  = w_line_we ? r_miss_idx : w_idx;

  assign p1_stall_o = w_miss;
  assign p1_data_o  = w_hit ? w_rd_line[{w_word, 5'b0} +: WORD_W] : '0;

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (w_rd_idx),
    .rd_valid_o  (w_rd_valid),
    .rd_dirty_o  (w_rd_dirty),
    .rd_tag_o    (w_rd_tag),
    .rd_line_o   (w_rd_line),
    .wr_idx_i    (w_wr_idx),
    .line_we_i   (w_line_we),
    .line_tag_i  (r_miss_tag),
    .line_data_i (mem_data_i),
    .word_we_i   (w_word_we),
    .word_sel_i  (w_word),
    .word_data_i (p1_data_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_miss) begin
        r_miss_tag <= w_tag;
        r_miss_idx <= w_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_miss) begin
          w_state_next = (w_rd_valid && w_rd_dirty) ? StWriteback : StRefill;
        end
      end
      StWriteback: if (mem_ack_i) w_state_next = StRefill;
      StRefill:    if (mem_ack_i) w_state_next = StIdle;
      default:     w_state_next = StIdle;
    endcase
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (r_state)
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(w_rd_tag, r_miss_idx);
        mem_data_o   = w_rd_line;
      end
      StRefill: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = line_addr(r_miss_tag, r_miss_idx);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed CPU accesses and a behavioural line memory
// with programmable ack latency; expected CPU and memory transactions are queued and checked.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_rd;
  logic         mem_wr_req;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data_out;
  logic [255:0] mem_data_in;
  logic         mem_ack;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_MemRead_i  (mem_rd),
    .p1_MemWrite_i (mem_wr_req),
    .p1_addr_i     (addr),
    .p1_data_i     (wdata),
    .p1_data_o     (rdata),
    .p1_stall_o    (stall),
    .mem_enable_o  (mem_enable),
    .mem_write_o   (mem_write),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data_out),
    .mem_data_i    (mem_data_in),
    .mem_ack_i     (mem_ack)
  );

  typedef struct {
    string       name;
    bit          is_load;
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    int          wsel;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t     cpu_q[$];
  mem_exp_t     mem_q[$];
  logic [255:0] mem_model [int unsigned];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int ack_delay = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 + (a << 4) + i;
    return l;
  endfunction

  // CPU-side monitor: one completion per cycle where a request is present without stall.
  int stall_cnt = 0;
  always @(negedge clk) begin
    cpu_exp_t e;
    if (rst || !(mem_rd || mem_wr_req)) begin
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt++;
    end else begin
      if (cpu_q.size() == 0) begin
        check("cpu_unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = cpu_q.pop_front();
        check({e.name, "_stall"}, stall_cnt, e.stall);
        if (e.is_load) check({e.name, "_data"}, rdata, e.data);
      end
      stall_cnt = 0;
      n_done++;
    end
  end

  // Behavioural line memory; ack after ack_delay waiting cycles of mem_enable.
  int          wait_cnt = 0;
  bit          in_xfer  = 0;
  bit          stable   = 1;
  logic [31:0] xfer_addr;
  logic        xfer_wr;
  always @(negedge clk) begin
    mem_exp_t e;
    mem_ack = 1'b0;
    if (rst || !mem_enable) begin
      wait_cnt = 0;
      in_xfer  = 0;
    end else begin
      if (!in_xfer) begin
        in_xfer   = 1;
        stable    = 1;
        xfer_addr = mem_addr;
        xfer_wr   = mem_write;
      end else if (mem_addr !== xfer_addr || mem_write !== xfer_wr) begin
        stable = 0;
      end
      if (wait_cnt == ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        in_xfer  = 0;
        if (xfer_wr) mem_model[xfer_addr] = mem_data_out;
        else mem_data_in = mem_model.exists(xfer_addr) ? mem_model[xfer_addr]
                                                       : init_line(xfer_addr);
        if (mem_q.size() == 0) begin
          check("mem_unexpected_request", xfer_addr, 32'hFFFF_FFFF);
        end else begin
          e = mem_q.pop_front();
          check({e.name, "_write"}, {31'd0, xfer_wr}, {31'd0, e.wr});
          check({e.name, "_addr"}, xfer_addr, e.addr);
          check({e.name, "_stable"}, {31'd0, stable}, 32'd1);
          if (e.wr) check({e.name, "_wbdata"}, mem_data_out[e.wsel*32 +: 32], e.wdata);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic exp_mem(input string nm, input bit wr, input logic [31:0] a,
                         input int wsel, input logic [31:0] wd);
    mem_exp_t e;
    e.name = nm; e.wr = wr; e.addr = a; e.wsel = wsel; e.wdata = wd;
    mem_q.push_back(e);
  endtask

  task automatic issue(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input int exp_stall);
    cpu_exp_t e;
    int start;
    bit done;
    e.name = nm; e.is_load = rd && !wr; e.data = exp_d; e.stall = exp_stall;
    @(posedge clk);
    #1;
    mem_rd = rd; mem_wr_req = wr; addr = a; wdata = d;
    cpu_q.push_back(e);
    start = n_done;
    done  = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      #1;
      if (n_done != start) done = 1;
    end
    if (!done) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr_req = 1'b0; addr = '0; wdata = '0;
    mem_data_in = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", {31'd0, |mem_data_out}, 32'd0);
    rst = 1'b0;

    // Cold load miss, then hits on the same line.
    ack_delay = 0;
    exp_mem("t1_refill", 0, 32'h40, 0, 0);
    issue("t1_load_miss", 1, 0, 32'h40, 0, 32'hA000_0400, 2);
    issue("t1_load_hit", 1, 0, 32'h40, 0, 32'hA000_0400, 0);
    issue("t1_load_w7", 1, 0, 32'h5C, 0, 32'hA000_0407, 0);

    // Store hit makes the line dirty.
    issue("t2_store_hit", 0, 1, 32'h44, 32'hDEAD_BEEF, 0, 0);
    issue("t2_load_back", 1, 0, 32'h44, 0, 32'hDEAD_BEEF, 0);
    issue("t2_load_w0", 1, 0, 32'h40, 0, 32'hA000_0400, 0);

    // Conflict miss on dirty line: write-back then refill.
    exp_mem("t3_wb", 1, 32'h40, 1, 32'hDEAD_BEEF);
    exp_mem("t3_refill", 0, 32'h440, 0, 0);
    issue("t3_load_conflict", 1, 0, 32'h440, 0, 32'hA000_4400, 3);
    exp_mem("t3_refetch", 0, 32'h40, 0, 0);
    issue("t3_load_wb_data", 1, 0, 32'h44, 0, 32'hDEAD_BEEF, 2);

    // Store miss to a clean line: refill only, then merge.
    exp_mem("t4_refill", 0, 32'h80, 0, 0);
    issue("t4_store_miss", 0, 1, 32'h88, 32'h1234_5678, 0, 2);
    issue("t4_load_merged", 1, 0, 32'h88, 0, 32'h1234_5678, 0);
    issue("t4_load_other", 1, 0, 32'h84, 0, 32'hA000_0801, 0);
    exp_mem("t4_wb", 1, 32'h80, 2, 32'h1234_5678);
    exp_mem("t4_refill2", 0, 32'h480, 0, 0);
    issue("t4_evict_dirty", 1, 0, 32'h480, 0, 32'hA000_4800, 3);

    // Memory latency variations.
    ack_delay = 1;
    exp_mem("t5_refill_d1", 0, 32'hC0, 0, 0);
    issue("t5_load_d1", 1, 0, 32'hC0, 0, 32'hA000_0C00, 3);
    ack_delay = 20;
    exp_mem("t5_refill_d20", 0, 32'hE0, 0, 0);
    issue("t5_load_d20", 1, 0, 32'hE4, 0, 32'hA000_0E01, 22);
    issue("t5_store_hit", 0, 1, 32'hE8, 32'hCAFE_F00D, 0, 0);
    exp_mem("t5_wb_d20", 1, 32'hE0, 2, 32'hCAFE_F00D);
    exp_mem("t5_refill2_d20", 0, 32'h4E0, 0, 0);
    issue("t5_dirty_d20", 1, 0, 32'h4E0, 0, 32'hA000_4E00, 43);

    // Reset in the middle of a refill.
    ack_delay = 50;
    @(posedge clk);
    #1;
    mem_rd = 1'b1; mem_wr_req = 1'b0; addr = 32'h100;
    repeat (3) @(negedge clk);
    #1;
    check("t6_pre_stall", {31'd0, stall}, 32'd1);
    check("t6_pre_enable", {31'd0, mem_enable}, 32'd1);
    check("t6_pre_addr", mem_addr, 32'h100);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_enable", {31'd0, mem_enable}, 32'd0);
    check("t6_rst_addr", mem_addr, 32'd0);
    mem_rd = 1'b0;
    #1;
    check("t6_rst_stall", {31'd0, stall}, 32'd0);
    check("t6_rst_data", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_delay = 0;
    exp_mem("t6_refill_40", 0, 32'h40, 0, 0);
    issue("t6_load_40_miss", 1, 0, 32'h40, 0, 32'hA000_0400, 2);
    exp_mem("t6_refill_80", 0, 32'h80, 0, 0);
    issue("t6_load_84_miss", 1, 0, 32'h84, 0, 32'hA000_0801, 2);

    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr_req = 1'b0;
    repeat (3) @(posedge clk);
    check("end_cpu_queue_empty", cpu_q.size(), 32'd0);
    check("end_mem_queue_empty", mem_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
